// File: rtl/multicore_launcher_pkg.sv
// -----------------------------------------------------------------------------
// details : shared types for the multicore launcher.
//   launch_state_t : sequencer states (IDLE, WAIT_READY, LAUNCH, RUN, FINISH)
//   mem_owner_t    : data/instruction memory owner (HOST = 0, CORES = 1)
// -----------------------------------------------------------------------------
package details;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_READY = 3'd1,
      LAUNCH     = 3'd2,
      RUN        = 3'd3,
      FINISH     = 3'd4
   } launch_state_t;

   typedef enum logic {
      HOST  = 1'b0,
      CORES = 1'b1
   } mem_owner_t;

endpackage

// File: rtl/multicore_launcher_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter : saturating up-counter with a sticky overflow flag.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the count and the overflow flag (wins over enable)
//   enable   : count one step this cycle
//   count    : current count, holds at all-ones
//   ovf      : set when an increment is requested at all-ones, sticky until clear
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             ovf
);

   logic [WIDTH-1:0] r_count;
   logic             r_ovf;
   logic             w_at_max;

   assign w_at_max = &r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (clear) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (enable) begin
         // The increment that would wrap is the one that flags overflow.
         if (w_at_max) begin
            r_ovf <= 1'b1;
         end else begin
            r_count <= r_count + WIDTH'(1);
         end
      end
   end

   assign count = r_count;
   assign ovf   = r_ovf;

endmodule

// File: rtl/multicore_launcher.sv
// -----------------------------------------------------------------------------
// multicore_launcher : starts all enabled processor cores in lock-step once
// they are ready, collects their done indications, measures the run length
// and hands memory ownership between the host loader and the cores.
//   clk, rst    : clock, asynchronous active-high reset
//   start_req   : host run request (level, held until finished)
//   core_mask   : enabled cores, latched on IDLE -> WAIT_READY
//   core_ready  : per-core ready
//   core_done   : per-core done (level or pulse)
//   core_start  : per-core start, one-cycle pulse in LAUNCH, masked
//   mem_sel     : HOST / CORES memory ownership
//   busy        : high outside IDLE and FINISH
//   finished    : high throughout FINISH
//   cycle_count : RUN cycles of the current/last run
//   count_ovf   : counter saturated during the current/last run
// All outputs decode from registered state only.
// -----------------------------------------------------------------------------
module multicore_launcher
   import details::*;
#(
   parameter int CORE_COUNT  = 4,
   parameter int CYCLE_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_req,
   input  logic [CORE_COUNT-1:0]  core_mask,
   input  logic [CORE_COUNT-1:0]  core_ready,
   input  logic [CORE_COUNT-1:0]  core_done,
   output logic [CORE_COUNT-1:0]  core_start,
   output mem_owner_t             mem_sel,
   output logic                   busy,
   output logic                   finished,
   output logic [CYCLE_WIDTH-1:0] cycle_count,
   output logic                   count_ovf
);

   launch_state_t          r_state;
   launch_state_t          w_state_next;
   logic [CORE_COUNT-1:0]  r_mask;
   logic [CORE_COUNT-1:0]  r_done_seen;
   logic                   r_blank;      // high during the first RUN cycle
   logic [CORE_COUNT-1:0]  w_done_now;
   logic                   w_done_all;
   logic                   w_latch;

   assign w_done_now = core_done & r_mask;
   assign w_done_all = ((r_done_seen | w_done_now) == r_mask);

   // Next-state and output decode.
   always_comb begin
      w_state_next = r_state;
      w_latch      = 1'b0;
      core_start   = '0;
      mem_sel      = HOST;
      busy         = 1'b0;
      finished     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_req) begin
               w_latch      = 1'b1;
               w_state_next = WAIT_READY;
            end
         end
         WAIT_READY: begin
            mem_sel = CORES;
            busy    = 1'b1;
            if ((core_ready & r_mask) == r_mask) begin
               w_state_next = LAUNCH;
            end
         end
         LAUNCH: begin
            mem_sel      = CORES;
            busy         = 1'b1;
            core_start   = r_mask;
            w_state_next = RUN;
         end
         RUN: begin
            mem_sel = CORES;
            busy    = 1'b1;
            // Blank cycle ignores done so a stale level from the last run is
            // not mistaken for completion.
            if (!r_blank && w_done_all) begin
               w_state_next = FINISH;
            end
         end
         FINISH: begin
            finished = 1'b1;
            if (!start_req) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_mask  <= '0;
         r_blank <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_blank <= (r_state == LAUNCH);
         if (w_latch) begin
            r_mask <= core_mask;
         end
      end
   end

   // Per-core done capture: cleared in LAUNCH, accumulated after the blank.
   generate
      for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_done
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_done_seen[gi] <= 1'b0;
            end else if (r_state == LAUNCH) begin
               r_done_seen[gi] <= 1'b0;
            end else if ((r_state == RUN) && !r_blank && w_done_now[gi]) begin
               r_done_seen[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   sat_counter #(
      .WIDTH (CYCLE_WIDTH)
   ) u_cycles (
      .clk    (clk),
      .rst    (rst),
      .clear  (w_latch),
      .enable (r_state == RUN),
      .count  (cycle_count),
      .ovf    (count_ovf)
   );

endmodule

// File: tb/tb_multicore_launcher.sv
module tb_multicore_launcher;
   import details::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_req = 1'b0;
   logic [3:0]  core_mask = '0;
   logic [3:0]  core_ready = '0;
   logic [3:0]  core_done = '0;

   logic [3:0]  core_start;
   mem_owner_t  mem_sel;
   logic        busy;
   logic        finished;
   logic [23:0] cycle_count;
   logic        count_ovf;

   logic [3:0]  start4;
   mem_owner_t  mem4;
   logic        busy4;
   logic        fin4;
   logic [3:0]  cnt4;
   logic        ovf4;

   int n_cmp = 0;
   int n_bad = 0;

   multicore_launcher #(.CORE_COUNT(4), .CYCLE_WIDTH(24)) dut (
      .clk (clk), .rst (rst), .start_req (start_req), .core_mask (core_mask),
      .core_ready (core_ready), .core_done (core_done), .core_start (core_start),
      .mem_sel (mem_sel), .busy (busy), .finished (finished),
      .cycle_count (cycle_count), .count_ovf (count_ovf)
   );

   // Narrow-counter instance sharing the same stimulus, used for saturation.
   multicore_launcher #(.CORE_COUNT(4), .CYCLE_WIDTH(4)) dut4 (
      .clk (clk), .rst (rst), .start_req (start_req), .core_mask (core_mask),
      .core_ready (core_ready), .core_done (core_done), .core_start (start4),
      .mem_sel (mem4), .busy (busy4), .finished (fin4),
      .cycle_count (cnt4), .count_ovf (ovf4)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Request a run and wait for the LAUNCH cycle; returns in RUN cycle 1.
   task automatic launch(input logic [3:0] mask, input logic [3:0] rdy_early,
                         input logic [3:0] rdy_late, input int delay, input int exp_wait);
      int waited;
      waited     = -1;
      core_mask  = mask;
      core_ready = rdy_early;
      start_req  = 1'b1;
      tick;
      check_val("wr_busy", busy, 1);
      check_val("wr_mem_sel", mem_sel, CORES);
      check_val("clr_count", cycle_count, 0);
      check_val("clr_count4", cnt4, 0);
      check_val("clr_ovf4", ovf4, 0);
      core_mask = ~mask;   // must be ignored after the latch
      for (int n = 0; n < 40; n++) begin
         core_ready = (n >= delay) ? rdy_late : rdy_early;
         tick;
         if (core_start != 4'd0 || mask == 4'd0) begin
            waited = n;
            break;
         end
      end
      check_val("wait_cycles", waited, exp_wait);
      check_val("launch_start", core_start, mask);
      tick;
      check_val("start_pulse_len", core_start, 0);
   endtask

   // Drive done pulses at given RUN cycles (0 = never) and find the finish cycle.
   task automatic run(input int d0, input int d1, input int d2, input int d3,
                      input bit stale, input int exp_cyc);
      int         fin;
      bit         extra_start;
      int         d[4];
      logic [3:0] dv;
      fin = 0;
      extra_start = 1'b0;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      for (int r = 1; r <= 60; r++) begin
         dv = 4'd0;
         for (int i = 0; i < 4; i++) if (d[i] == r) dv[i] = 1'b1;
         if (stale && r == 1) dv = 4'hF;
         core_done = dv;
         if (core_start != 4'd0) extra_start = 1'b1;
         tick;
         core_done = 4'd0;
         if (finished) begin
            fin = r;
            break;
         end
      end
      check_val("finish_cycle", fin, exp_cyc);
      check_val("no_extra_start", extra_start, 0);
      check_val("cycle_count", cycle_count, exp_cyc);
      check_val("fin_mem_sel", mem_sel, HOST);
      check_val("fin_busy", busy, 0);
   endtask

   task automatic end_run;
      start_req = 1'b0;
      tick;
      check_val("idle_finished", finished, 0);
      check_val("idle_busy", busy, 0);
   endtask

   initial begin
      #2 rst = 1'b1;
      tick;
      tick;
      check_val("rst_start", core_start, 0);
      check_val("rst_mem_sel", mem_sel, HOST);
      check_val("rst_busy", busy, 0);
      check_val("rst_finished", finished, 0);
      check_val("rst_count", cycle_count, 0);
      check_val("rst_ovf", count_ovf, 0);
      rst = 1'b0;
      tick;

      // Basic run, dones at RUN cycles 5, 9, 7, 12.
      launch(4'hF, 4'hF, 4'hF, 0, 0);
      run(5, 9, 7, 12, 1'b0, 12);
      end_run();

      // Partial mask; cores 1 and 3 never ready nor done.
      launch(4'h5, 4'h5, 4'h5, 0, 0);
      run(5, 0, 7, 0, 1'b0, 7);
      end_run();

      // Core 2 ready six cycles late.
      launch(4'hF, 4'hB, 4'hF, 6, 6);
      run(2, 2, 2, 2, 1'b0, 2);
      end_run();

      // Stale done level in the blank cycle, real dones at RUN cycle 8.
      launch(4'hF, 4'hF, 4'hF, 0, 0);
      run(8, 8, 8, 8, 1'b1, 8);
      end_run();

      // Long run: narrow counter saturates at 15 and flags overflow.
      launch(4'hF, 4'hF, 4'hF, 0, 0);
      run(20, 20, 20, 20, 1'b0, 20);
      check_val("sat_count4", cnt4, 4'hF);
      check_val("sat_ovf4", ovf4, 1);
      check_val("wide_ovf", count_ovf, 0);
      end_run();
      check_val("ovf4_held_idle", ovf4, 1);

      // Reset in RUN cycle 3, then an all-masked-off run.
      launch(4'hF, 4'hF, 4'hF, 0, 0);
      tick;
      tick;
      rst = 1'b1;
      #1;
      check_val("mid_rst_busy", busy, 0);
      check_val("mid_rst_mem_sel", mem_sel, HOST);
      check_val("mid_rst_start", core_start, 0);
      check_val("mid_rst_count", cycle_count, 0);
      start_req = 1'b0;
      tick;
      rst = 1'b0;
      tick;
      launch(4'h0, 4'h0, 4'h0, 0, 0);
      run(0, 0, 0, 0, 1'b0, 2);
      end_run();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
